// File: rtl/sgf_align_grs_if.sv
// Request/result bundle between exponent compare, the significand aligner and
// the significand adder.
interface sgf_align_grs_if #(
  parameter int SW = 26,
  parameter int EW = 8
);
  logic          start_i;
  logic          flush_i;
  logic [SW-1:0] sgf_i;
  logic [EW-1:0] shamt_i;
  logic          ack_i;
  logic          ready_o;
  logic          valid_o;
  logic [SW-1:0] sgf_o;
  logic [1:0]    grs_o;

  modport master (
    output start_i, flush_i, sgf_i, shamt_i, ack_i,
    input  ready_o, valid_o, sgf_o, grs_o
  );

  modport slave (
    input  start_i, flush_i, sgf_i, shamt_i, ack_i,
    output ready_o, valid_o, sgf_o, grs_o
  );
endinterface

// File: rtl/sgf_align_grs.sv
// Sequential right-shift aligner: shifts one bit per cycle and collects
// {guard, sticky} for the round-decision logic.
module sgf_align_grs #(
  parameter int SW = 26,
  parameter int EW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  sgf_align_grs_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Shifting SW+1 places already moves every bit past guard into sticky.
  localparam logic [EW:0] SAT = (EW+1)'(SW + 1);

  state_t        r_state;
  logic [SW-1:0] r_sgf;
  logic          r_guard;
  logic          r_sticky;
  logic [EW:0]   r_cnt;
  logic          r_ready;
  logic          r_valid;

  logic [EW:0]   w_shamt;
  logic [EW:0]   w_eff;

  assign w_shamt = {1'b0, bus.shamt_i};
  assign w_eff   = (w_shamt > SAT) ? SAT : w_shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sgf    <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
    end else if (bus.flush_i) begin
      r_state  <= IDLE;
      r_sgf    <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_sgf    <= bus.sgf_i;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= w_eff;
            r_ready  <= 1'b0;
            if (w_eff == '0) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_sticky <= r_sticky | r_guard;
          r_guard  <= r_sgf[0];
          r_sgf    <= {1'b0, r_sgf[SW-1:1]};
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt <= (EW+1)'(1)) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.ack_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.valid_o = r_valid;
  assign bus.sgf_o   = r_sgf;
  assign bus.grs_o   = {r_guard, r_sticky};

endmodule
